// File: rtl/serial_word_pkg.sv
// Shared types and sizing helpers for the serial word collector and its bit counter.
package serial_word_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } coll_state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_MATCH = 10;

  // Counter must hold the full frame length, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down-counter; decrement saturates at zero so the count never wraps.
module serial_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dec_en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             zero_s;

  assign zero_s = (count_q == {CNT_W{1'b0}});

  // Load has priority over decrement.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_en_i && !zero_s) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = zero_s;

endmodule

// File: rtl/serial_word_collector.sv
// Collects a framed serial bit stream into a WIDTH-bit word and flags a match
// against a fixed constant; one-cycle out_valid pulse per completed frame.
module serial_word_collector
  import serial_word_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MATCH     = WIDTH'(DEFAULT_MATCH),
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             match,
  output logic             busy,
  output logic             cnt_zero
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LOAD_VAL = CW'(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = {{(CW-1){1'b0}}, 1'b1};

  coll_state_t      state_q,  state_d;
  logic [WIDTH-1:0] shift_q,  shift_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             match_q,  match_d;
  logic             valid_q,  valid_d;
  logic             busy_q,   busy_d;

  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic [CW-1:0]    cnt_load_val_s;
  logic [CW-1:0]    cnt_s;
  logic             cnt_zero_s;
  logic [WIDTH-1:0] next_word_s;

  serial_bit_counter #(
    .CNT_W (CW)
  ) u_bit_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load_s),
    .dec_en_i   (cnt_dec_s),
    .load_val_i (cnt_load_val_s),
    .count_o    (cnt_s),
    .zero_o     (cnt_zero_s)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign next_word_s = {shift_q[WIDTH-2:0], ser_in};
    end else begin : g_lsb_first
      assign next_word_s = {ser_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state logic: abort beats a last-bit sample; start is only honoured in IDLE/DONE.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    data_d         = data_q;
    match_d        = match_q;
    valid_d        = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_dec_s      = 1'b0;
    cnt_load_val_s = LOAD_VAL;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_load_s = 1'b1;
          shift_d    = {WIDTH{1'b0}};
          state_d    = SHIFT;
        end else begin
          state_d    = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          cnt_load_s     = 1'b1;
          cnt_load_val_s = {CW{1'b0}};
          state_d        = IDLE;
        end else if (ser_valid && !cnt_zero_s) begin
          shift_d   = next_word_s;
          cnt_dec_s = 1'b1;
          if (cnt_s == LAST_BIT) begin
            data_d  = next_word_s;
            match_d = (next_word_s == MATCH);
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else if (cnt_zero_s) begin
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        cnt_load_s     = 1'b1;
        cnt_load_val_s = {CW{1'b0}};
        state_d        = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
  end

  // FSM, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= {WIDTH{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      match_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      match_q <= match_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign match     = match_q;
  assign busy      = busy_q;
  assign cnt_zero  = cnt_zero_s;

endmodule

// File: tb/tb_serial_word_collector.sv
// Scoreboard bench: an MSB-first and an LSB-first collector share one serial stream.
module tb_serial_word_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, ser_in = 1'b0, ser_valid = 1'b0;
  logic [7:0] data_m, data_l;
  logic       ov_m, ov_l, match_m, match_l, busy_m, busy_l, cz_m, cz_l;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses_m = 0;
  int last_pulse_m = 0;
  int prev_pulse_m = 0;
  logic [8:0] exp_m[$];
  logic [8:0] exp_l[$];

  serial_word_collector #(.WIDTH(8), .MATCH(8'd10), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ser_in(ser_in), .ser_valid(ser_valid),
    .data_out(data_m), .out_valid(ov_m), .match(match_m), .busy(busy_m), .cnt_zero(cz_m));

  serial_word_collector #(.WIDTH(8), .MATCH(8'd10), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ser_in(ser_in), .ser_valid(ser_valid),
    .data_out(data_l), .out_valid(ov_l), .match(match_l), .busy(busy_l), .cnt_zero(cz_l));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && ov_m) begin
      pulses_m++;
      prev_pulse_m = last_pulse_m;
      last_pulse_m = cyc;
      n_checks++;
      if (exp_m.size() == 0) begin
        n_fail++;
        $display("FAIL sb_msb_unexpected: out_valid with data %h, no frame expected", data_m);
      end else begin
        e = exp_m.pop_front();
        if ({match_m, data_m} !== e) begin
          n_fail++;
          $display("FAIL sb_msb_word: got match=%b data=%h, expected match=%b data=%h", match_m, data_m, e[8], e[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && ov_l) begin
      n_checks++;
      if (exp_l.size() == 0) begin
        n_fail++;
        $display("FAIL sb_lsb_unexpected: out_valid with data %h, no frame expected", data_l);
      end else begin
        e = exp_l.pop_front();
        if ({match_l, data_l} !== e) begin
          n_fail++;
          $display("FAIL sb_lsb_word: got match=%b data=%h, expected match=%b data=%h", match_l, data_l, e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] seq);
    logic [7:0] r;
    r = rev8(seq);
    exp_m.push_back({seq == 8'd10, seq});
    exp_l.push_back({r == 8'd10, r});
  endtask

  // seq[7] is the first bit on the wire; with gaps, start is pulsed in each idle gap cycle.
  task automatic drive_frame(input logic [7:0] seq, input bit gaps);
    push_exp(seq);
    start = 1'b1; abort = 1'b0; ser_valid = 1'b0;
    tick;
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (gaps && i != 7) begin
        ser_valid = 1'b0; ser_in = ~seq[i]; start = 1'b1;
        tick;
        start = 1'b0;
      end
      ser_in = seq[i]; ser_valid = 1'b1;
      tick;
    end
    ser_valid = 1'b0; ser_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    sample;
    n_checks++;
    if ({data_m, ov_m, match_m, busy_m, cz_m} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_msb: got data=%h ov=%b match=%b busy=%b cz=%b, expected 00 0 0 0 1", data_m, ov_m, match_m, busy_m, cz_m);
    end
    n_checks++;
    if ({data_l, ov_l, match_l, busy_l, cz_l} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_lsb: got data=%h ov=%b match=%b busy=%b cz=%b, expected 00 0 0 0 1", data_l, ov_l, match_l, busy_l, cz_l);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [7:0] seq;
    seq = 8'b0000_1010;
    push_exp(seq);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      ser_in = seq[i]; ser_valid = 1'b1;
      sample;
      n_checks++;
      if (ov_m !== 1'b0 || busy_m !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_in_frame bit %0d: got ov=%b busy=%b, expected ov=0 busy=1", 7 - i, ov_m, busy_m);
      end
      tick;
    end
    ser_valid = 1'b0;
    sample;
    n_checks++;
    if ({ov_m, busy_m, match_m, data_m} !== {1'b1, 1'b0, 1'b1, 8'h0A}) begin
      n_fail++;
      $display("FAIL basic_latency: got ov=%b busy=%b match=%b data=%h, expected 1 0 1 0a", ov_m, busy_m, match_m, data_m);
    end
    tick;
    sample;
    n_checks++;
    if ({ov_m, busy_m} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_pulse_width: got ov=%b busy=%b, expected 0 0", ov_m, busy_m);
    end
    tick;
  endtask

  task automatic test_gaps;
    int p0;
    p0 = pulses_m;
    drive_frame(8'hA5, 1'b1);
    sample;
    n_checks++;
    if (ov_m !== 1'b1 || pulses_m !== p0 + 1 || data_m !== 8'hA5 || match_m !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_frame: got ov=%b pulses=%0d data=%h match=%b, expected 1 %0d a5 0", ov_m, pulses_m - p0, data_m, match_m, 1);
    end
    tick;
  endtask

  task automatic test_lsb_first;
    drive_frame(8'b0101_0000, 1'b0);
    sample;
    n_checks++;
    if ({ov_l, match_l, data_l} !== {1'b1, 1'b1, 8'h0A}) begin
      n_fail++;
      $display("FAIL lsb_first: got ov=%b match=%b data=%h, expected 1 1 0a", ov_l, match_l, data_l);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    drive_frame(8'h0A, 1'b0);
    sample;
    n_checks++;
    if ({ov_m, data_m} !== {1'b1, 8'h0A}) begin
      n_fail++;
      $display("FAIL b2b_first: got ov=%b data=%h, expected 1 0a", ov_m, data_m);
    end
    drive_frame(8'hFF, 1'b0);
    sample;
    n_checks++;
    if ({ov_m, match_m, data_m} !== {1'b1, 1'b0, 8'hFF} || (last_pulse_m - prev_pulse_m) !== 9) begin
      n_fail++;
      $display("FAIL b2b_second: got ov=%b match=%b data=%h spacing=%0d, expected 1 0 ff 9", ov_m, match_m, data_m, last_pulse_m - prev_pulse_m);
    end
    tick;
  endtask

  task automatic test_abort;
    logic [7:0] seq;
    int p0;
    drive_frame(8'h0A, 1'b0);
    tick;
    p0 = pulses_m;
    seq = 8'h33;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 7; i >= 3; i--) begin
      ser_in = seq[i]; ser_valid = 1'b1;
      tick;
    end
    abort = 1'b1; ser_in = 1'b0;
    tick;
    abort = 1'b0; ser_valid = 1'b0;
    sample;
    n_checks++;
    if ({ov_m, busy_m, cz_m, match_m, data_m} !== {1'b0, 1'b0, 1'b1, 1'b1, 8'h0A}) begin
      n_fail++;
      $display("FAIL abort_mid: got ov=%b busy=%b cz=%b match=%b data=%h, expected 0 0 1 1 0a", ov_m, busy_m, cz_m, match_m, data_m);
    end
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      ser_in = seq[i]; ser_valid = 1'b1;
      tick;
    end
    abort = 1'b1; ser_in = seq[0];
    tick;
    abort = 1'b0; ser_valid = 1'b0;
    sample;
    n_checks++;
    if ({ov_m, busy_m, cz_m, data_m} !== {1'b0, 1'b0, 1'b1, 8'h0A} || pulses_m !== p0) begin
      n_fail++;
      $display("FAIL abort_last_bit: got ov=%b busy=%b cz=%b data=%h extra_pulses=%0d, expected 0 0 1 0a 0", ov_m, busy_m, cz_m, data_m, pulses_m - p0);
    end
    tick;
  endtask

  task automatic test_reset_midframe;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ser_in = 1'b1; ser_valid = 1'b1;
      tick;
    end
    ser_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({data_m, ov_m, match_m, busy_m, cz_m} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset_msb: got data=%h ov=%b match=%b busy=%b cz=%b, expected 00 0 0 0 1", data_m, ov_m, match_m, busy_m, cz_m);
    end
    n_checks++;
    if ({data_l, busy_l, cz_l} !== {8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset_lsb: got data=%h busy=%b cz=%b, expected 00 0 1", data_l, busy_l, cz_l);
    end
    #1 rst = 1'b0;
    tick;
    drive_frame(8'h0A, 1'b0);
    sample;
    n_checks++;
    if ({ov_m, match_m, data_m} !== {1'b1, 1'b1, 8'h0A}) begin
      n_fail++;
      $display("FAIL post_reset_frame: got ov=%b match=%b data=%h, expected 1 1 0a", ov_m, match_m, data_m);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_lsb_first;
    test_back_to_back;
    test_abort;
    test_reset_midframe;
    repeat (3) tick;
    n_checks++;
    if (exp_m.size() != 0 || exp_l.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d/%0d frames still pending, expected 0/0", exp_m.size(), exp_l.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Receive-side counterpart of the shift/count serializer datapath.
- Accepts a framed serial bit stream, shifts bits into a word register and counts them down to zero.
- Presents the assembled word with a one-cycle valid pulse.
- Flags when the word equals a programmable match constant (default 10, the value the control unit compares against).

Parameters:
- WIDTH, 8, bits per frame (2..32).
- MATCH, 10, compare constant for the match flag (WIDTH bits).
- MSB_FIRST, 1, 1: first received bit lands in bit WIDTH-1; 0: first bit lands in bit 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a new frame (sampled in IDLE or DONE).
- abort  input  1  cancel the current frame (effective in SHIFT).
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is valid this cycle.
- data_out  output  WIDTH  last completed word.
- out_valid  output  1  one-cycle pulse: new data_out/match.
- match  output  1  data_out == MATCH.
- busy  output  1  frame in progress (state SHIFT).
- cnt_zero  output  1  bit counter is zero (status mirror of n_0).

Behaviour:
- Reset (async assert, sync deassert by the user):
  - state=IDLE, shift register=0, counter=0.
  - data_out=0, out_valid=0, match=0, busy=0, cnt_zero=1.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 -> counter<=WIDTH, shift reg<=0, next SHIFT. Otherwise stay.
  - SHIFT, on each cycle with ser_valid=1:
    - Shift ser_in into the register (left shift with LSB insert if MSB_FIRST, else right shift with MSB insert).
    - counter<=counter-1.
    - If counter==1 on that cycle (last bit): data_out<=assembled word including this bit, match<=(word==MATCH), next DONE.
  - SHIFT, ser_valid=0: hold everything.
  - DONE: out_valid=1 for exactly this one cycle.
    - start=1 -> reload counter, clear shift reg, next SHIFT (back-to-back frames with no IDLE cycle).
    - Otherwise next IDLE.
- Latency: out_valid is high in the cycle immediately after the clock edge that samples the last bit.
  - Minimum frame, start through out_valid: WIDTH+2 cycles with ser_valid held high.
- data_out and match hold until the next completed frame. They are not cleared by start or abort.
- Simultaneous events:
  - start in SHIFT: ignored.
  - abort in SHIFT: next IDLE, counter<=0, no out_valid, data_out/match unchanged. abort takes priority over a last-bit ser_valid in the same cycle.
  - abort in IDLE/DONE: ignored. start wins in DONE.
  - ser_valid in IDLE/DONE: bits discarded.
- busy=1 exactly while state==SHIFT. cnt_zero=(counter==0), combinational from the counter register.
- Counter width $clog2(WIDTH+1), unsigned. The counter never wraps: decrement is only enabled while SHIFT is active and counter>0.
- Reset mid-frame: immediate return to reset values. No partial word is ever presented.

Decomposition:
- Package serial_word_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} coll_state_t.
  - localparam for the counter width function.
- Sub-module serial_bit_counter (load, dec_en, load_val -> count, zero), shared in form with the serializer's counter.
- FSM, shift register and output registers live in the top module.

Test Plan:
- WIDTH=8, MSB_FIRST=1, start then bits 0,0,0,0,1,0,1,0 with ser_valid held high -> out_valid pulse 1 cycle, 9 cycles after start is sampled; data_out=0x0A; match=1; busy low afterwards.
- Same frame with ser_valid low on alternate cycles, bits 1,0,1,0,0,1,0,1 -> data_out=0xA5, match=0; out_valid only after the 8th valid bit; no pulse before it.
- MSB_FIRST=0, bits 0,1,0,1,0,0,0,0 -> data_out=0x0A, match=1.
- Frame 0x0A completes, start asserted in the DONE cycle, second frame 0xFF -> two out_valid pulses; second gives data_out=0xFF, match=0; no IDLE cycle between the frames.
- abort after 5 bits of frame 0x33 -> no out_valid; data_out keeps the previous value 0x0A; busy=0 next cycle; cnt_zero=1.
- rst pulsed asynchronously mid-frame (between clock edges) after 3 bits -> outputs read 0, busy=0, cnt_zero=1 before the next clock edge. A fresh frame 0x0A afterwards completes correctly.
